// File: rtl/cache_tester.sv
// -----------------------------------------------------------------------------
// cache_tester
//
// Self-checking traffic generator for the CPU-side port of the cache. A start
// pulse writes a deterministic pattern over a window of 2^WORD_COUNT_BITWIDTH
// words, reads the window back and compares every word. Status outputs are
// registered and steady enough to drive board LEDs.
//
// Pattern: P(a) = a ^ SEED ^ {a[15:0], a[31:16]}, a = byte address.
//
// Optional feature macro: CACHE_TESTER_BYTE_WRITE_EN
//   When defined, a byte pass follows the word pass. Each word is rewritten
//   one lane at a time (strobes 0001, 0010, 0100, 1000) with ~P(a), then the
//   window is read back expecting ~P(a).
//
// Ports:
//   clk            in   cache clock (PSRAM controller clk_out domain)
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse, accepted only in IDLE/DONE/FAIL
//   address        out  cache byte address
//   data_in        out  cache write data
//   write_enable   out  byte-lane write strobes, 0 = read
//   data_out       in   cache read data
//   data_out_ready in   data_out valid for the current address
//   busy           in   cache stalled on miss/eviction, hold request
//   running        out  test in progress
//   done           out  test finished without mismatch
//   fail           out  mismatch detected
//   fail_address   out  address of the first mismatch
//   fail_data      out  data_out captured at the first mismatch
// -----------------------------------------------------------------------------
module cache_tester #(
    parameter logic [31:0] START_ADDRESS       = 32'h0000_0000,
    parameter int          WORD_COUNT_BITWIDTH = 10,
    parameter logic [31:0] SEED                = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] address,
    output logic [31:0] data_in,
    output logic [3:0]  write_enable,
    input  logic [31:0] data_out,
    input  logic        data_out_ready,
    input  logic        busy,
    output logic        running,
    output logic        done,
    output logic        fail,
    output logic [31:0] fail_address,
    output logic [31:0] fail_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_DONE,
        S_FAIL
`ifdef CACHE_TESTER_BYTE_WRITE_EN
        ,
        S_BW_ISSUE,
        S_BW_WAIT,
        S_BR_ISSUE,
        S_BR_WAIT
`endif
    } state_t;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ SEED ^ {a[15:0], a[31:16]};
    endfunction

    state_t                         r_state;
    logic [WORD_COUNT_BITWIDTH-1:0] r_idx;
    // Set on entry to a WAIT state so that every WAIT lasts at least two
    // cycles; this also discards a data_out_ready left over from the
    // previous address.
    logic                           r_first;
    logic [31:0]                    r_address;
    logic [31:0]                    r_data_in;
    logic [3:0]                     r_we;
    logic                           r_running;
    logic                           r_done;
    logic                           r_fail;
    logic [31:0]                    r_fail_address;
    logic [31:0]                    r_fail_data;
`ifdef CACHE_TESTER_BYTE_WRITE_EN
    logic [1:0]                     r_lane;
`endif

    logic [WORD_COUNT_BITWIDTH-1:0] w_next_idx;
    logic [31:0]                    w_next_addr;
    logic [31:0]                    w_pattern;
    logic [31:0]                    w_next_pattern;
    logic                           w_last;
    logic                           w_wait_done;
    logic                           w_read_valid;

    // Index wraps modulo the window, so the address after the last word is
    // START_ADDRESS again and the next pass begins without extra muxing.
    assign w_next_idx     = r_idx + WORD_COUNT_BITWIDTH'(1);
    assign w_next_addr    = START_ADDRESS + (32'(w_next_idx) << 2);
    assign w_pattern      = pattern(r_address);
    assign w_next_pattern = pattern(w_next_addr);
    assign w_last         = (r_idx == '1);
    assign w_wait_done    = !r_first && !busy;
    assign w_read_valid   = !r_first && !busy && data_out_ready;

    assign address      = r_address;
    assign data_in      = r_data_in;
    assign write_enable = r_we;
    assign running      = r_running;
    assign done         = r_done;
    assign fail         = r_fail;
    assign fail_address = r_fail_address;
    assign fail_data    = r_fail_data;

    // Outputs are loaded on the edge that enters each ISSUE state, so the
    // request is visible for the whole ISSUE cycle and held through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_first        <= 1'b0;
            r_address      <= START_ADDRESS;
            r_data_in      <= '0;
            r_we           <= '0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            r_fail_address <= '0;
            r_fail_data    <= '0;
`ifdef CACHE_TESTER_BYTE_WRITE_EN
            r_lane         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every branch below reads
            // the pre-edge register values regardless of statement order.
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_idx          <= '0;
                        r_address      <= START_ADDRESS;
                        r_data_in      <= pattern(START_ADDRESS);
                        r_we           <= 4'b1111;
                        r_running      <= 1'b1;
                        r_done         <= 1'b0;
                        r_fail         <= 1'b0;
                        r_fail_address <= '0;
                        r_fail_data    <= '0;
                        r_state        <= S_WR_ISSUE;
                    end
                end

                S_WR_ISSUE: begin
                    r_we    <= 4'b0000;
                    r_first <= 1'b1;
                    r_state <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    r_first <= 1'b0;
                    if (w_wait_done) begin
                        r_idx     <= w_next_idx;
                        r_address <= w_next_addr;
                        if (w_last) begin
                            r_state <= S_RD_ISSUE;
                        end else begin
                            r_data_in <= w_next_pattern;
                            r_we      <= 4'b1111;
                            r_state   <= S_WR_ISSUE;
                        end
                    end
                end

                S_RD_ISSUE: begin
                    r_first <= 1'b1;
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    r_first <= 1'b0;
                    if (w_read_valid) begin
                        if (data_out != w_pattern) begin
                            r_fail_address <= r_address;
                            r_fail_data    <= data_out;
                            r_fail         <= 1'b1;
                            r_running      <= 1'b0;
                            r_state        <= S_FAIL;
                        end else if (!w_last) begin
                            r_idx     <= w_next_idx;
                            r_address <= w_next_addr;
                            r_state   <= S_RD_ISSUE;
                        end else begin
`ifdef CACHE_TESTER_BYTE_WRITE_EN
                            r_idx     <= w_next_idx;
                            r_address <= w_next_addr;
                            r_data_in <= ~w_next_pattern;
                            r_we      <= 4'b0001;
                            r_lane    <= 2'd0;
                            r_state   <= S_BW_ISSUE;
`else
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
`endif
                        end
                    end
                end

`ifdef CACHE_TESTER_BYTE_WRITE_EN
                S_BW_ISSUE: begin
                    r_we    <= 4'b0000;
                    r_first <= 1'b1;
                    r_state <= S_BW_WAIT;
                end

                S_BW_WAIT: begin
                    r_first <= 1'b0;
                    if (w_wait_done) begin
                        if (r_lane != 2'd3) begin
                            // Same word, next lane: address and data stay put.
                            r_lane  <= r_lane + 2'd1;
                            r_we    <= 4'b0001 << (r_lane + 2'd1);
                            r_state <= S_BW_ISSUE;
                        end else begin
                            r_lane    <= 2'd0;
                            r_idx     <= w_next_idx;
                            r_address <= w_next_addr;
                            if (w_last) begin
                                r_state <= S_BR_ISSUE;
                            end else begin
                                r_data_in <= ~w_next_pattern;
                                r_we      <= 4'b0001;
                                r_state   <= S_BW_ISSUE;
                            end
                        end
                    end
                end

                S_BR_ISSUE: begin
                    r_first <= 1'b1;
                    r_state <= S_BR_WAIT;
                end

                S_BR_WAIT: begin
                    r_first <= 1'b0;
                    if (w_read_valid) begin
                        if (data_out != ~w_pattern) begin
                            r_fail_address <= r_address;
                            r_fail_data    <= data_out;
                            r_fail         <= 1'b1;
                            r_running      <= 1'b0;
                            r_state        <= S_FAIL;
                        end else if (!w_last) begin
                            r_idx     <= w_next_idx;
                            r_address <= w_next_addr;
                            r_state   <= S_BR_ISSUE;
                        end else begin
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tester.sv
// -----------------------------------------------------------------------------
// tb_cache_tester
//
// Directed bench for cache_tester. A behavioural cache model answers on the
// falling edge (zero latency, optional periodic stalls, optional corrupted
// address). Each expected request is queued before start and popped when the
// DUT issues it.
// -----------------------------------------------------------------------------
module tb_cache_tester;

`ifdef CACHE_TESTER_BYTE_WRITE_EN
    localparam int          TB_N        = 2;
    localparam int          BYTE_WR_EXP = 16;
    localparam logic [31:0] CORRUPT_A   = 32'h0000_0008;
`else
    localparam int          TB_N        = 4;
    localparam int          BYTE_WR_EXP = 0;
    localparam logic [31:0] CORRUPT_A   = 32'h0000_0024;
`endif
    localparam int          W        = 1 << TB_N;
    localparam logic [31:0] TB_SEED  = 32'hA5A5_0000;
`ifdef CACHE_TESTER_BYTE_WRITE_EN
    localparam int          PASS_CYC = 6 * W + 1 + 15 * W;
`else
    localparam int          PASS_CYC = 6 * W + 1;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        bit          chk;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_enable;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        running;
    logic        done;
    logic        fail;
    logic [31:0] fail_address;
    logic [31:0] fail_data;

    cache_tester #(
        .START_ADDRESS      (32'h0000_0000),
        .WORD_COUNT_BITWIDTH(TB_N),
        .SEED               (TB_SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .address       (address),
        .data_in       (data_in),
        .write_enable  (write_enable),
        .data_out      (data_out),
        .data_out_ready(data_out_ready),
        .busy          (busy),
        .running       (running),
        .done          (done),
        .fail          (fail),
        .fail_address  (fail_address),
        .fail_data     (fail_data)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    acc_t        exp_q[$];
    logic [31:0] obs_wdata[$];
    logic [31:0] mem[0:255];
    int          busy_cnt = 0;
    int          acc_cnt  = 0;
    int          n_acc    = 0;
    int          n_byte_wr = 0;
    bit          stall_en   = 1'b0;
    bit          corrupt_en = 1'b0;
    bit          new_acc;
    acc_t        e_cur;
    logic [31:0] prev_addr = '0;
    logic [3:0]  prev_we   = '0;
    logic [31:0] hold_addr = '0;
    logic [31:0] hold_data = '0;
    logic        first_done, first_fail, first_running;
    logic [31:0] first_fail_addr;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ TB_SEED ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Cache model and request monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt       = 0;
            busy           = 1'b0;
            data_out_ready = 1'b0;
            data_out       = '0;
            prev_we        = '0;
            prev_addr      = address;
        end else begin
            if (busy) begin
                check("stall_addr_hold", address, hold_addr);
                check("stall_data_hold", data_in, hold_data);
            end
            if (prev_we != 4'b0)
                check("we_one_cycle", {28'b0, write_enable}, 32'h0);

            if (busy_cnt > 0) busy_cnt--;
            new_acc = running && (write_enable != 4'b0 || address != prev_addr);
            if (new_acc) begin
                n_acc++;
                acc_cnt++;
                if (stall_en && (acc_cnt % 4 == 0)) busy_cnt = 20;
                check("access_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e_cur = exp_q.pop_front();
                    check("acc_addr", address, e_cur.addr);
                    check("acc_we", {28'b0, write_enable}, {28'b0, e_cur.we});
                    if (e_cur.chk) check("acc_data", data_in, e_cur.data);
                end
                if (write_enable != 4'b0) begin
                    obs_wdata.push_back(data_in);
                    if (write_enable != 4'b1111) n_byte_wr++;
                    for (int k = 0; k < 4; k++)
                        if (write_enable[k]) mem[address[9:2]][8*k +: 8] = data_in[8*k +: 8];
                end
            end
            busy           = (busy_cnt > 0);
            data_out_ready = !busy;
            data_out       = (corrupt_en && address == CORRUPT_A) ? 32'hDEAD_BEEF
                                                                  : mem[address[9:2]];
            prev_addr = address;
            prev_we   = write_enable;
            hold_addr = address;
            hold_data = data_in;
        end
    end

    // Queue the full request sequence of one pass; rd_words limits the word
    // read pass (for a pass that is expected to stop at a mismatch).
    task automatic push_pass(input int rd_words);
        for (int i = 0; i < W; i++)
            exp_q.push_back('{addr: 32'(4 * i), data: pat(32'(4 * i)), we: 4'b1111, chk: 1'b1});
        for (int i = 0; i < rd_words; i++)
            exp_q.push_back('{addr: 32'(4 * i), data: '0, we: 4'b0000, chk: 1'b0});
`ifdef CACHE_TESTER_BYTE_WRITE_EN
        if (rd_words == W) begin
            for (int i = 0; i < W; i++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{addr: 32'(4 * i), data: ~pat(32'(4 * i)),
                                      we: 4'(1 << k), chk: 1'b1});
            for (int i = 0; i < W; i++)
                exp_q.push_back('{addr: 32'(4 * i), data: '0, we: 4'b0000, chk: 1'b0});
        end
`endif
    endtask

    // Pulse start, then wait for done/fail within budget cycles. Cycle 1 is
    // the edge that samples start. poke_at >= 0 re-pulses start mid-test.
    task automatic run_test(input int budget, input int poke_at, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start           = 1'b0;
        cycles          = 1;
        first_done      = done;
        first_fail      = fail;
        first_running   = running;
        first_fail_addr = fail_address;
        while (!(done || fail) && cycles < budget) begin
            start = (cycles == poke_at);
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_address"}, address, 32'h0);
        check({tag, "_data_in"}, data_in, 32'h0);
        check({tag, "_we"}, {28'b0, write_enable}, 32'h0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_fail_addr"}, fail_address, 32'h0);
        check({tag, "_fail_data"}, fail_data, 32'h0);
    endtask

    task automatic check_pass_ok(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc_snap;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        start = 1'b0;
        busy = 1'b0;
        data_out_ready = 1'b0;
        data_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1. Zero-latency cache, full pass, exact cycle count.
        obs_wdata.delete();
        n_byte_wr = 0;
        push_pass(W);
        run_test(5000, -1, cyc);
        check("t1_cycles", 32'(cyc), 32'(PASS_CYC));
        check("t1_running_at_start", 32'(first_running), 32'd1);
        check_pass_ok("t1");
        check("t1_p0", obs_wdata[0], 32'hA5A5_0000);
        check("t1_p4", obs_wdata[1], 32'hA5A1_0004);
        check("t1_byte_writes", 32'(n_byte_wr), 32'(BYTE_WR_EXP));
`ifdef CACHE_TESTER_BYTE_WRITE_EN
        check("t1_first_byte_data", obs_wdata[W], 32'h5A5A_FFFF);
        check("t1_mem0_inverted", mem[0], 32'h5A5A_FFFF);
`endif

        // 2. Cache stalls 20 cycles on every 4th access.
        stall_en = 1'b1;
        acc_cnt  = 0;
        push_pass(W);
        run_test(5000, -1, cyc);
        check("t2_stalls_slowed", 32'(cyc > PASS_CYC), 32'd1);
        check_pass_ok("t2");
        stall_en = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // 3. Corrupted read data: fail with address/data, then silence.
        corrupt_en = 1'b1;
        push_pass(int'(CORRUPT_A >> 2) + 1);
        run_test(5000, -1, cyc);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_running", 32'(running), 32'd0);
        check("t3_fail_addr", fail_address, CORRUPT_A);
        check("t3_fail_data", fail_data, 32'hDEAD_BEEF);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        acc_snap = n_acc;
        repeat (30) @(posedge clk);
        #1;
        check("t3_no_more_access", 32'(n_acc), 32'(acc_snap));
        check("t3_fail_held", 32'(fail), 32'd1);
        corrupt_en = 1'b0;

        // Restart from FAIL clears the status on acceptance.
        push_pass(W);
        run_test(5000, -1, cyc);
        check("t3r_fail_cleared", 32'(first_fail), 32'd0);
        check("t3r_fail_addr_cleared", first_fail_addr, 32'h0);
        check_pass_ok("t3r");

        // 4. Reset asserted during RD_WAIT of the first read.
        push_pass(W);
        run_test(3 * W + 2, -1, cyc);
        check("t4_mid_running", 32'(running), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("t4_abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_pass(W);
        run_test(5000, -1, cyc);
        check("t4_cycles", 32'(cyc), 32'(PASS_CYC));
        check_pass_ok("t4");

        // 5. Restart from DONE, with a stray start mid-test that is ignored.
        push_pass(W);
        run_test(5000, 20, cyc);
        check("t5_done_cleared", 32'(first_done), 32'd0);
        check("t5_running_set", 32'(first_running), 32'd1);
        check("t5_cycles", 32'(cyc), 32'(PASS_CYC));
        check_pass_ok("t5");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
